mux8_1_cond: RTL and testbench
==============================

MUX8_1_COND -- requirements
Module: mux8_1_cond

Interface
REQ-001 Parameter: OUT_REG, default 1, output register enable (1 = registered outputs, 0 = combinational outputs).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: sel  input  3  select index, 0..7.
REQ-005 Port: a  input  8  data inputs; a[i] is the candidate for sel == i.
REQ-006 Port: f  output  1  selected bit a[sel].
REQ-007 Port: f_logic  output  1  same selection computed by the gate-level path.
REQ-008 Port: mismatch  output  1  high when f and f_logic disagree.

Function
REQ-009 The block SHALL compute a conditional-select result, f_c = a[sel], using a priority-free case/conditional decode of sel.
REQ-010 The block SHALL compute an independent gate-level result, f_g, as a sum of products: OR over i of (a[i] AND decoded sel == i), using only AND/OR/NOT terms.
REQ-011 For all 2048 combinations of sel and a, f_c SHALL equal f_g.
REQ-012 With OUT_REG=1, f, f_logic and mismatch SHALL be registered with one-cycle latency:
- f = f_c of the previous edge.
- f_logic = f_g of the previous edge.
- mismatch = (f_c != f_g) of the previous edge.
REQ-013 With OUT_REG=0, f, f_logic and mismatch SHALL be purely combinational with zero latency, and clk/rst SHALL have no effect on them.
REQ-014 Every sel value SHALL be valid; there is no out-of-range case, and the default decode branch SHALL never be reachable.
REQ-015 If sel or a carries X/Z, f SHALL not be required to be defined; no X-propagation guarantees apply.
REQ-016 When sel and a change in the same cycle, the registered outputs SHALL reflect the new combination after one edge.

Reset
REQ-017 With OUT_REG=1, rst high at a rising clk edge SHALL force f=0, f_logic=0, mismatch=0.
REQ-018 Reset SHALL take priority over input capture; the first capture occurs at the first edge with rst low.
REQ-019 Asserting reset mid-stream SHALL clear the outputs on that edge; no other state exists.

Structure
REQ-020 No shared package is needed; the select width (3) and data width (8) SHALL be local constants.
REQ-021 The gate-level path SHALL be a single sub-module named mux8_1_logic, with ports sel[2:0], a[7:0], f.
REQ-022 The conditional path and output registers SHALL reside in the top module.

Verification
REQ-023 Exhaustive sweep: every sel 0..7 crossed with every a 0..255, one clock per vector, with OUT_REG=1 -> f == a[sel] one cycle later and mismatch == 0 throughout.
REQ-024 Directed selection: a=8'b1000_0000 with sel=7 -> f=1; the same a with sel=0..6 -> f=0.
REQ-025 Walking one: a=8'h01 shifted left 0..7 with sel tracking the shift -> f=1 at every step; sel offset by 1 from the shift -> f=0.
REQ-026 Reset: drive a=8'hFF, sel=3 and hold rst high for 2 edges -> f=f_logic=mismatch=0; after rst falls -> f=1 on the next edge.
REQ-027 Combinational variant: OUT_REG=0, a=8'hA5, sel=2 -> f=1 with no clock edge; sel=1 -> f=0 immediately.
REQ-028 Path equivalence: a random 1000-vector run -> f == f_logic on every cycle and mismatch never asserted.

Source files
------------

// File: rtl/mux8_1_logic.sv
// mux8_1_logic: gate-level 8:1 mux as a sum of products (ports: sel[2:0] select, a[7:0] data, f selected bit)
module mux8_1_logic (
  input  logic [2:0] sel,
  input  logic [7:0] a,
  output logic       f
);
  localparam int SW = 3;
  localparam int DW = 8;
  logic [SW-1:0] nsel;
  logic [DW-1:0] t;
  assign nsel = ~sel;
  for (genvar i = 0; i < DW; i++) begin : g_t
    localparam logic [SW-1:0] K = SW'(i);
    // each select literal is wired to sel or ~sel at elaboration, leaving a pure AND term
    assign t[i] = a[i] & (K[2] ? sel[2] : nsel[2]) & (K[1] ? sel[1] : nsel[1]) & (K[0] ? sel[0] : nsel[0]);
  end
  assign f = |t;
endmodule

// File: rtl/mux8_1_cond.sv
// mux8_1_cond: 8:1 mux via conditional decode, cross-checked against a gate-level path (ports: clk, rst sync active-high, sel[2:0], a[7:0] -> f, f_logic, mismatch)
module mux8_1_cond #(
  parameter bit OUT_REG = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sel,
  input  logic [7:0] a,
  output logic       f,
  output logic       f_logic,
  output logic       mismatch
);
  logic f_c;
  logic f_g;
  always_comb begin
    f_c = 1'b0;
    case (sel)
      3'd0: f_c = a[0];
      3'd1: f_c = a[1];
      3'd2: f_c = a[2];
      3'd3: f_c = a[3];
      3'd4: f_c = a[4];
      3'd5: f_c = a[5];
      3'd6: f_c = a[6];
      3'd7: f_c = a[7];
      default: f_c = 1'b0;
    endcase
  end
  mux8_1_logic u_logic (
    .sel(sel),
    .a  (a),
    .f  (f_g)
  );
  if (OUT_REG) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        f        <= 1'b0;
        f_logic  <= 1'b0;
        mismatch <= 1'b0;
      end else begin
        f        <= f_c;
        f_logic  <= f_g;
        mismatch <= f_c ^ f_g;
      end
    end
  end else begin : g_comb
    assign f        = f_c;
    assign f_logic  = f_g;
    assign mismatch = f_c ^ f_g;
  end
endmodule

// File: tb/tb_mux8_1_cond.sv
// tb_mux8_1_cond: self-checking bench for registered and combinational variants of mux8_1_cond
module tb_mux8_1_cond;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] sel;
  logic [7:0] a;
  logic f, f_logic, mismatch;
  logic fc, fc_logic, fc_mismatch;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux8_1_cond #(.OUT_REG(1)) dut (
    .clk(clk), .rst(rst), .sel(sel), .a(a),
    .f(f), .f_logic(f_logic), .mismatch(mismatch)
  );

  mux8_1_cond #(.OUT_REG(0)) dut_c (
    .clk(clk), .rst(rst), .sel(sel), .a(a),
    .f(fc), .f_logic(fc_logic), .mismatch(fc_mismatch)
  );

  function automatic logic ref_bit(input logic [2:0] s, input logic [7:0] d);
    return 1'((d >> s) & 8'd1);
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic exp);
    check({tag, ".f"}, f, exp);
    check({tag, ".f_logic"}, f_logic, exp);
    check({tag, ".mismatch"}, mismatch, 1'b0);
  endtask

  task automatic step(input string tag, input logic [2:0] s, input logic [7:0] d);
    logic e;
    sel = s;
    a = d;
    e = ref_bit(s, d);
    #1;
    check({tag, ".comb_f"}, fc, e);
    check({tag, ".comb_mm"}, fc_mismatch, 1'b0);
    @(posedge clk);
    #1;
    check_reg(tag, e);
  endtask

  initial begin
    rst = 1'b1;
    sel = 3'd3;
    a = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check_reg("reset", 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reg("reset_release", 1'b1);

    for (int s = 0; s < 8; s++)
      for (int d = 0; d < 256; d++)
        step("sweep", 3'(s), 8'(d));

    for (int s = 0; s < 8; s++)
      step("msb_only", 3'(s), 8'b1000_0000);

    for (int k = 0; k < 8; k++) begin
      step("walk_on", 3'(k), 8'h01 << k);
      step("walk_off", 3'(k + 1), 8'h01 << k);
    end

    sel = 3'd5;
    a = 8'h20;
    @(posedge clk);
    #1;
    check_reg("pre_rst", 1'b1);
    rst = 1'b1;
    a = 8'hFF;
    sel = 3'd3;
    @(posedge clk);
    #1;
    check_reg("mid_rst1", 1'b0);
    @(posedge clk);
    #1;
    check_reg("mid_rst2", 1'b0);
    check("rst_comb_f", fc, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reg("post_rst", 1'b1);

    a = 8'hA5;
    sel = 3'd2;
    #1;
    check("comb_a5_s2", fc, 1'b1);
    check("comb_a5_s2_logic", fc_logic, 1'b1);
    sel = 3'd1;
    #1;
    check("comb_a5_s1", fc, 1'b0);
    check("comb_a5_s1_logic", fc_logic, 1'b0);

    for (int n = 0; n < 1000; n++)
      step("random", 3'($urandom_range(7)), 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
